uart_txrx: RTL
==============

# uart_txrx

Serial transceiver core consuming the one-cycle `tx_wr` strobes and producing the `rx_data`/`rx_avail`/`rx_error` status that the J1 UART bus peripheral reads and acknowledges. Sits between that peripheral and the `uart_txd`/`uart_rxd` pins to the Bluetooth module. Implements 8N1 framing, a 16x oversampled receiver with start-bit validation, and sticky status with acknowledge.

## Interface
- `freq_hz`, 100000000, system clock frequency in Hz.
- `baud`, 115200, line rate in bit/s.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_wr`  in  1  one-cycle request to send `tx_data`.
- `tx_data`  in  8  byte to send; sampled only on the accepting cycle.
- `tx_busy`  out  1  high while a frame is being transmitted.
- `uart_txd`  out  1  serial output; idle high.
- `uart_rxd`  in  1  asynchronous serial input.
- `rx_data`  out  8  last correctly framed received byte.
- `rx_avail`  out  1  sticky: new byte in `rx_data`.
- `rx_error`  out  1  sticky: framing error or overrun since last ack.
- `rx_ack`  in  1  one-cycle acknowledge; clears `rx_avail` and `rx_error`.

Clock is `clk`, reset is `reset`: one clock, reset synchronous and active-high.

## Operation
- Oversample divider `DIV = (freq_hz + 8*baud) / (16*baud)`, integer, minimum 1 (100 MHz/115200 gives 54). Bit period `BIT = 16*DIV` clocks.
- Reset values: `uart_txd`=1, `tx_busy`=0, `rx_data`=0, `rx_avail`=0, `rx_error`=0. Both FSMs go to IDLE. Divider and bit counters are cleared. Reset mid-frame aborts the frame, and `uart_txd` is high the next cycle.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE: `tx_wr` accepted only if `tx_busy`=0. The accepting cycle latches `tx_data` and restarts the TX bit timer. `tx_wr` is ignored while busy, with no queueing.
  - START drives 0, DATA drives bits 0..7 (LSB first), STOP drives 1. Each state lasts exactly BIT clocks, timed by a TX-private counter, not by the free-running tick.
  - Returns to IDLE at the end of STOP.
- RX path:
  - `uart_rxd` passes through a 2-flop synchronizer, giving `rxd_s`.
  - A free-running tick pulses one clock every DIV clocks.
  - RX FSM: IDLE, START, DATA, STOP, BREAK.
    - IDLE: on a tick with `rxd_s`=0, go to START and clear the tick count.
    - START: after 8 ticks (mid-bit), if `rxd_s`=0 go to DATA, else false start and return to IDLE.
    - DATA: every 16 ticks sample `rxd_s` into a shift register, LSB first. After 8 samples go to STOP.
    - STOP: after 16 ticks sample `rxd_s`.
      - If 1: `rx_data` takes the shift register and `rx_avail` is set to 1. If `rx_avail` was already 1, this is an overrun: data is overwritten and `rx_error` is set to 1. Return to IDLE.
      - If 0: framing error. `rx_error` is set to 1; `rx_data` and `rx_avail` are unchanged. Go to BREAK.
    - BREAK: wait for `rxd_s`=1, then return to IDLE.
- `rx_ack` clears `rx_avail` and `rx_error` on the next edge. If `rx_ack` and a stop-bit completion fall in the same cycle, the completion wins: flags reflect the new frame and the old flags are cleared first.
- TX and RX are fully independent; full-duplex operation is required.

## Timing
- `tx_wr` in cycle N (idle): `tx_busy`=1 and `uart_txd`=0 from cycle N+1.
- `tx_busy` is high for exactly 10*BIT clocks and falls with the stop bit's end.
- A `tx_wr` in the first cycle `tx_busy`=0 is accepted, allowing back-to-back frames with no idle gap.
- RX sampling point: about mid-bit, plus 2-clock synchronizer latency and up to DIV clocks of tick jitter.
- `rx_avail` rises about 9.5*BIT + 3 clocks after the start-bit falling edge.
- Outputs are registered; no combinational path from input to output.

## Structure
- Shared include `uart_defs.vh`: TX and RX state encodings (localparams), and the `DIV` computation macro so the bus peripheral and benches agree on the bit period.
- One sub-module, `uart_baud_tick`: parameterised free-running divider with synchronous reset, producing a one-clock `tick` every DIV clocks. The TX bit timer stays inside `uart_txrx`.

## Test plan
Run with `freq_hz`=3200000 and `baud`=100000, giving DIV=2 and BIT=32.
- Reset release, then `tx_wr` with `tx_data`=8'hA5: `uart_txd` shows 0,1,0,1,0,0,1,0,1,1 with 32 clocks per bit. `tx_busy` is high for exactly 320 clocks.
- A second `tx_wr` (8'h3C) mid-frame is ignored. A `tx_wr` (8'h3C) on the first non-busy cycle produces a contiguous second frame.
- Drive an RX frame for 8'h5A: `rx_avail`=1 and `rx_data`=8'h5A, `rx_error`=0. `rx_ack` clears `rx_avail` the next cycle.
- Low glitch of 10 clocks on `uart_rxd`: no state change, `rx_avail` stays 0. Frame with stop bit 0 (data 8'hFF): `rx_error`=1, `rx_data` unchanged, and no new frame starts until the line returns high.
- Two frames (8'h11 then 8'h22) with no ack: `rx_data`=8'h22, `rx_avail`=1, `rx_error`=1. An ack in the stop-completion cycle of a third frame leaves `rx_avail`=1.
- Assert `reset` mid-TX and mid-RX: next cycle `uart_txd`=1, `tx_busy`=0, all RX flags are 0, and a subsequent 8'h81 round-trip (txd looped to rxd) is received correctly.

Source files
------------

// File: rtl/uart_txrx_pkg.sv
// Shared types and helpers for the uart_txrx transceiver: FSM encodings and the
// oversample divider calculation so peripherals and benches agree on the bit period.
package uart_txrx_pkg;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

    // Rounded freq/(16*baud), never below 1.
    function automatic int unsigned calc_div(input int unsigned freq_hz, input int unsigned baud);
        int unsigned d;
        d = (freq_hz + 8 * baud) / (16 * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_txrx_if.sv
// Bus-side signals between the J1 UART peripheral (master) and the transceiver core (slave).
interface uart_txrx_if;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack;

    modport master (output tx_wr, tx_data, rx_ack,
                    input  tx_busy, rx_data, rx_avail, rx_error);
    modport slave  (input  tx_wr, tx_data, rx_ack,
                    output tx_busy, rx_data, rx_avail, rx_error);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-clock tick every Div clocks, synchronous reset.
module uart_baud_tick #(
    parameter int unsigned Div = 54
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || cnt_q == Last) cnt_q <= '0;
        else                        cnt_q <= cnt_q + 1'b1;
    end

    assign tick = (cnt_q == Last);
endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART transceiver: bit-timed transmitter plus 16x oversampled receiver with
// start validation and sticky avail/error flags cleared by acknowledge.
module uart_txrx
    import uart_txrx_pkg::*;
#(
    parameter int unsigned freq_hz = 100000000,
    parameter int unsigned baud    = 115200
) (
    input  logic         clk,
    input  logic         reset,
    uart_txrx_if.slave   bus,
    output logic         uart_txd,
    input  logic         uart_rxd
);
    localparam int unsigned Div     = calc_div(freq_hz, baud);
    localparam int unsigned BitClks = 16 * Div;
    localparam int unsigned TimerW  = $clog2(BitClks);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(BitClks - 1);

    // ---------------- transmitter ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [TimerW-1:0] tx_timer_q, tx_timer_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              txd_q, txd_d;
    logic              tx_busy_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_timer_d = '0;
                if (bus.tx_wr) begin
                    tx_state_d = TxStart;
                    tx_shift_d = bus.tx_data;
                end
            end
            TxStart: if (tx_timer_q == TimerLast) begin
                tx_state_d = TxData;
                tx_timer_d = '0;
                tx_bit_d   = '0;
            end
            TxData: if (tx_timer_q == TimerLast) begin
                tx_timer_d = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 1'b1;
                if (tx_bit_q == 3'd7) tx_state_d = TxStop;
            end
            TxStop: if (tx_timer_q == TimerLast) begin
                tx_state_d = TxIdle;
                tx_timer_d = '0;
            end
            default: tx_state_d = TxIdle;
        endcase
        // Line level is registered from the next state so it changes with the state.
        unique case (tx_state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_timer_q <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_busy_q  <= (tx_state_d != TxIdle);
        end
    end

    assign uart_txd    = txd_q;
    assign bus.tx_busy = tx_busy_q;

    // ---------------- receiver ----------------
    logic rxd_meta_q, rxd_s;
    logic tick;

    uart_baud_tick #(.Div(Div)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_ticks_q, rx_ticks_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_avail_q, rx_avail_d;
    logic       rx_error_q, rx_error_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_ticks_d = rx_ticks_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        // Ack clears first so a same-cycle stop completion still raises the flags.
        rx_avail_d = rx_avail_q & ~bus.rx_ack;
        rx_error_d = rx_error_q & ~bus.rx_ack;
        unique case (rx_state_q)
            RxIdle: if (tick && !rxd_s) begin
                rx_state_d = RxStart;
                rx_ticks_d = '0;
            end
            RxStart: if (tick) begin
                if (rx_ticks_q == 4'd7) begin
                    rx_ticks_d = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s ? RxIdle : RxData;
                end else begin
                    rx_ticks_d = rx_ticks_q + 1'b1;
                end
            end
            RxData: if (tick) begin
                rx_ticks_d = rx_ticks_q + 1'b1;
                if (rx_ticks_q == 4'd15) begin
                    rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: if (tick) begin
                rx_ticks_d = rx_ticks_q + 1'b1;
                if (rx_ticks_q == 4'd15) begin
                    if (rxd_s) begin
                        rx_data_d  = rx_shift_q;
                        rx_error_d = rx_error_d | rx_avail_d;
                        rx_avail_d = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_error_d = 1'b1;
                        rx_state_d = RxBreak;
                    end
                end
            end
            RxBreak: if (rxd_s) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_s      <= 1'b1;
            rx_state_q <= RxIdle;
            rx_ticks_q <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_avail_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s      <= rxd_meta_q;
            rx_state_q <= rx_state_d;
            rx_ticks_q <= rx_ticks_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_avail_q <= rx_avail_d;
            rx_error_q <= rx_error_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_avail = rx_avail_q;
    assign bus.rx_error = rx_error_q;
endmodule
